dmux4way16_stream: RTL and testbench
====================================

Name: dmux4way16_stream

Overview:
- Registered 4-way 16-bit demultiplexer, the inverse of the 4-way 16-bit mux in the datapath.
- Takes a single valid/ready input stream tagged with a 2-bit destination select.
- Routes each accepted word into one of four per-destination FIFOs (a, b, c, d), each with an independent valid/ready output.
- Used to fan CPU-side writes out to four consumers (screen, keyboard shadow, two expansion ports) that may stall independently.

Parameters:
- WIDTH, 16: data width of input and of each output channel.
- DEPTH, 2: entries per channel FIFO; must be a power of two and ≥ 2.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  WIDTH  input data word.
- sel  input  2  destination: 0→a, 1→b, 2→c, 3→d.
- in_valid  input  1  in/sel hold a word to transfer.
- in_ready  output  1  the FIFO selected by the current sel can accept a word.
- a, b, c, d  output  WIDTH  head-of-FIFO data for each channel.
- a_valid, b_valid, c_valid, d_valid  output  1  the channel FIFO is non-empty.
- a_ready, b_ready, c_ready, d_ready  input  1  the consumer takes the head word this cycle.
- busy  output  1  OR of all four channel valids.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All FIFOs empty; read and write pointers and occupancy counts are 0.
  - Storage cleared to 0. a..d = 0, all *_valid = 0, busy = 0.
  - in_ready = 1, because every FIFO is empty.
  - Reset asserted mid-transfer discards all queued words, with no partial delivery.
- Input handshake:
  - A word is accepted on a rising edge where in_valid && in_ready.
  - The word and sel are sampled on that same edge.
  - in_ready is combinational and equals !full[sel], where full is the registered occupancy == DEPTH.
  - in_ready never depends on any output ready. There is no pass-through when a full FIFO is popped in the same cycle: a full channel refuses input that cycle.
  - Words for different channels never block each other. A stalled channel only blocks input while sel points at it.
- Push latency:
  - A word accepted at edge N is visible on its channel output (x_valid = 1, x = word) after edge N.
  - There is no same-cycle bypass into an empty FIFO.
- Output handshake:
  - The head word pops on an edge where x_valid && x_ready.
  - x holds the head entry and must stay stable while x_valid && !x_ready.
  - x_ready while x_valid = 0 is ignored.
- Simultaneous push and pop on one channel: occupancy is unchanged, the head advances, and the new word is appended at the tail.
- Ordering: strict FIFO order per channel. Words to different channels have no ordering relationship.
- Pointers: log2(DEPTH) bits, wrapping modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits, range 0..DEPTH.
- When a channel is empty, x shows the stale value at the read pointer. Consumers must qualify x with x_valid.
- sel or in changing while in_valid = 1 and not accepted is legal; only the value at the accepting edge matters.
- busy is registered-derived: it is high whenever any FIFO is non-empty.

Test Plan:
- Reset release, all ready = 1 → in_ready = 1, all valids = 0, a..d = 0x0000, busy = 0.
- Send 0x1111 sel=0, then 0x2222 sel=1, 0x3333 sel=2, 0x4444 sel=3 on consecutive cycles with all ready = 1 → each word appears on a/b/c/d exactly one cycle after its acceptance, for one cycle each; busy drops after the last pop.
- Hold b_ready = 0 and send 0xAAA0..0xAAA2 to sel=1 (DEPTH=2):
  - Required: in_ready = 0 after two words; the third is held.
  - In the meantime 0x5555 to sel=3 is accepted.
  - Releasing b_ready delivers 0xAAA0, 0xAAA1, 0xAAA2 in order.
- Channel c full with c_ready = 1 and in_valid sel=2 in the same cycle → in_ready = 0 that cycle (no pass-through); the word is accepted the following cycle.
- Channel a holds 1 entry, with push 0xBEEF and pop in the same cycle → occupancy stays 1, a = 0xBEEF next cycle. Run 10 push/pop pairs to confirm pointer wrap.
- Queue 2 words in each of a and d, then pulse rst_n low asynchronously between edges → all valids drop immediately, in_ready = 1, and no queued word appears after release.

Source files
------------

// File: rtl/dmux4way16_stream.sv
//------------------------------------------------------------------------------
// Module  : dmux4way16_stream
// Brief   : Registered 4-way demultiplexer. It routes a valid/ready input
//           stream into four independent per-destination FIFOs.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmux4way16_stream #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             a_valid,
    output logic             b_valid,
    output logic             c_valid,
    output logic             d_valid,
    input  logic             a_ready,
    input  logic             b_ready,
    input  logic             c_ready,
    input  logic             d_ready,
    output logic             busy
);

    localparam int            c_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(DEPTH);

    logic [3:0]       w_ready;
    logic [3:0]       w_valid;
    logic [3:0]       w_full;
    logic [WIDTH-1:0] w_head [4];

    assign w_ready = {d_ready, c_ready, b_ready, a_ready};

    // Full is taken from registered occupancy only, so a full channel never
    // accepts a word in the same cycle it is popped.
    assign in_ready = !w_full[sel];

    generate
        for (genvar i = 0; i < 4; i++) begin : g_chan
            logic [WIDTH-1:0] r_mem [DEPTH];
            logic [c_AW-1:0]  r_wptr;
            logic [c_AW-1:0]  r_rptr;
            logic [c_AW:0]    r_cnt;
            logic             w_push;
            logic             w_pop;

            assign w_valid[i] = (r_cnt != '0);
            assign w_full[i]  = (r_cnt == c_FULL);
            assign w_head[i]  = r_mem[r_rptr];
            assign w_push     = in_valid && !w_full[i] && (sel == 2'(i));
            assign w_pop      = w_valid[i] && w_ready[i];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        r_mem[k] <= '0;
                    end
                    r_wptr <= '0;
                    r_rptr <= '0;
                    r_cnt  <= '0;
                end else begin
                    if (w_push) begin
                        r_mem[r_wptr] <= in;
                        r_wptr        <= r_wptr + 1'b1;
                    end
                    if (w_pop) begin
                        r_rptr <= r_rptr + 1'b1;
                    end
                    if (w_push && !w_pop) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else if (w_pop && !w_push) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign a       = w_head[0];
    assign b       = w_head[1];
    assign c       = w_head[2];
    assign d       = w_head[3];
    assign a_valid = w_valid[0];
    assign b_valid = w_valid[1];
    assign c_valid = w_valid[2];
    assign d_valid = w_valid[3];
    assign busy    = |w_valid;

endmodule

`default_nettype wire

// File: tb/tb_dmux4way16_stream.sv
//------------------------------------------------------------------------------
// Module  : tb_dmux4way16_stream
// Brief   : Directed self-checking bench for dmux4way16_stream.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmux4way16_stream;

    logic        clk;
    logic        rst_n;
    logic [15:0] in;
    logic [1:0]  sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b, c, d;
    logic        a_valid, b_valid, c_valid, d_valid;
    logic        a_ready, b_ready, c_ready, d_ready;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    dmux4way16_stream #(.WIDTH(16), .DEPTH(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in),
        .sel      (sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .a_valid  (a_valid),
        .b_valid  (b_valid),
        .c_valid  (c_valid),
        .d_valid  (d_valid),
        .a_ready  (a_ready),
        .b_ready  (b_ready),
        .c_ready  (c_ready),
        .d_ready  (d_ready),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; checks happen on the falling edge.
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [15:0] w);
        in_valid = v;
        sel      = s;
        in       = w;
    endtask

    logic [15:0] prev;

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 2'd0, 16'h0);
        {a_ready, b_ready, c_ready, d_ready} = 4'b1111;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_valids", {a_valid, b_valid, c_valid, d_valid}, 0);
        check_eq("rst_data", {a, b}, 0);
        check_eq("rst_data_cd", {c, d}, 0);
        check_eq("rst_busy", busy, 0);

        // One word per channel on consecutive cycles, all consumers ready
        next_cycle; drive(1, 2'd0, 16'h1111);
        @(negedge clk); check_eq("s_in_ready", in_ready, 1);
        next_cycle; drive(1, 2'd1, 16'h2222);
        @(negedge clk); check_eq("s_a", {a_valid, a}, {1'b1, 16'h1111});
        next_cycle; drive(1, 2'd2, 16'h3333);
        @(negedge clk);
        check_eq("s_a_gone", a_valid, 0);
        check_eq("s_b", {b_valid, b}, {1'b1, 16'h2222});
        next_cycle; drive(1, 2'd3, 16'h4444);
        @(negedge clk);
        check_eq("s_b_gone", b_valid, 0);
        check_eq("s_c", {c_valid, c}, {1'b1, 16'h3333});
        next_cycle; drive(0, 2'd0, 16'h0);
        @(negedge clk);
        check_eq("s_d", {d_valid, d}, {1'b1, 16'h4444});
        check_eq("s_busy", busy, 1);
        next_cycle;
        @(negedge clk);
        check_eq("s_busy_drop", busy, 0);

        // Stalled channel b fills; channel d still flows
        b_ready = 0;
        drive(1, 2'd1, 16'hAAA0);
        next_cycle; drive(1, 2'd1, 16'hAAA1);
        @(negedge clk);
        check_eq("b_first", {b_valid, b}, {1'b1, 16'hAAA0});
        check_eq("b_rdy1", in_ready, 1);
        next_cycle; drive(1, 2'd1, 16'hAAA2);
        @(negedge clk); check_eq("b_full_rdy", in_ready, 0);
        next_cycle; drive(1, 2'd3, 16'h5555);
        @(negedge clk); check_eq("d_rdy_while_b_full", in_ready, 1);
        next_cycle; drive(1, 2'd1, 16'hAAA2);
        @(negedge clk);
        check_eq("d_5555", {d_valid, d}, {1'b1, 16'h5555});
        check_eq("b_still_full", in_ready, 0);
        check_eq("b_head_stable", b, 16'hAAA0);
        next_cycle; b_ready = 1;
        @(negedge clk); check_eq("b_no_passthru", in_ready, 0);
        next_cycle;
        @(negedge clk);
        check_eq("b_second", {b_valid, b}, {1'b1, 16'hAAA1});
        check_eq("b_rdy_again", in_ready, 1);
        next_cycle; drive(0, 2'd0, 16'h0);
        @(negedge clk); check_eq("b_third", {b_valid, b}, {1'b1, 16'hAAA2});
        next_cycle;
        @(negedge clk); check_eq("b_empty", b_valid, 0);

        // Channel c full while its consumer pops: input refused that cycle
        c_ready = 0;
        drive(1, 2'd2, 16'hC000);
        next_cycle; drive(1, 2'd2, 16'hC001);
        next_cycle; drive(1, 2'd2, 16'hC002); c_ready = 1;
        @(negedge clk);
        check_eq("c_full_pop_rdy", in_ready, 0);
        check_eq("c_head0", c, 16'hC000);
        next_cycle;
        @(negedge clk);
        check_eq("c_rdy_next", in_ready, 1);
        check_eq("c_head1", c, 16'hC001);
        next_cycle; drive(0, 2'd0, 16'h0);
        @(negedge clk); check_eq("c_head2", {c_valid, c}, {1'b1, 16'hC002});
        next_cycle;
        @(negedge clk); check_eq("c_empty", c_valid, 0);

        // Channel a at occupancy 1 with push and pop together, through pointer wrap
        a_ready = 0;
        drive(1, 2'd0, 16'h0A00);
        next_cycle; drive(1, 2'd0, 16'hBEEF); a_ready = 1;
        @(negedge clk); check_eq("a_one", {a_valid, a}, {1'b1, 16'h0A00});
        prev = 16'hBEEF;
        for (int i = 0; i < 10; i++) begin
            next_cycle; drive(1, 2'd0, 16'hB000 + 16'(i));
            @(negedge clk);
            check_eq($sformatf("a_pp%0d", i), {in_ready, a_valid, a}, {2'b11, prev});
            prev = 16'hB000 + 16'(i);
        end
        next_cycle; drive(0, 2'd0, 16'h0);
        @(negedge clk); check_eq("a_last", {a_valid, a}, {1'b1, 16'hB009});
        next_cycle;
        @(negedge clk); check_eq("a_empty", a_valid, 0);

        // Asynchronous reset with words queued in a and d
        a_ready = 0; d_ready = 0;
        drive(1, 2'd0, 16'h0A01);
        next_cycle; drive(1, 2'd0, 16'h0A02);
        next_cycle; drive(1, 2'd3, 16'h0D01);
        next_cycle; drive(1, 2'd3, 16'h0D02);
        next_cycle; drive(0, 2'd0, 16'h0);
        @(negedge clk);
        check_eq("q_valids", {a_valid, d_valid, busy}, 3'b111);
        #2 rst_n = 0;
        #1;
        check_eq("ar_valids", {a_valid, b_valid, c_valid, d_valid}, 0);
        check_eq("ar_busy_rdy", {busy, in_ready}, 2'b01);
        check_eq("ar_data", {a, d}, 0);
        @(posedge clk); #1 rst_n = 1; a_ready = 1; d_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("post_rst%0d", i), {a_valid, d_valid, busy}, 0);
            next_cycle;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
